// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART program loader.
// loader_state_t : frame-level state machine encoding
// *_DEFAULT      : default protocol constants, overridable per instance
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_ADDR,
    S_HDR_CNT,
    S_CHECK,
    S_DATA,
    S_WRITE,
    S_SUM,
    S_RESP
  } loader_state_t;

  localparam logic [7:0] MAGIC_DEFAULT     = 8'hA5;
  localparam logic [7:0] ACK_DEFAULT       = 8'h06;
  localparam logic [7:0] NAK_DEFAULT       = 8'h15;
  localparam int         MAX_BYTES_DEFAULT = 8192;
  localparam int         TIMEOUT_DEFAULT   = 25_000_000;

endpackage

// File: rtl/uart_loader_if.sv
// Memory bus between the loader (master) and BRAM (slave).
// mem_valid : request, held until mem_ready is sampled high
// mem_instr : instruction fetch flag (loader never fetches)
// mem_addr  : byte address, word aligned
// mem_wdata : write data
// mem_wstrb : byte enables
// mem_ready : responder completion
interface uart_loader_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready
  );
endinterface

// File: rtl/uart_loader.sv
// UART program loader: receives a framed image
//   MAGIC, ADDR[4], COUNT[2], DATA[4*COUNT], SUM   (little-endian)
// and writes it word by word into BRAM, answering each frame with ACK/NAK.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   rx_received/rx_byte      received byte strobe and data
//   rx_error                 receive framing error strobe
//   tx_trigger/tx_byte       response send strobe and byte
//   tx_busy                  transmitter busy
//   bus                      memory bus master
//   loader_active            frame in progress (SoC muxes the bus and holds CPU in reset)
//   load_done                pulse with an ACK response
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
  parameter int         MAX_BYTES      = MAX_BYTES_DEFAULT,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_received,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_error,
  output logic                 tx_trigger,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  uart_loader_if.master        bus,
  output logic                 loader_active,
  output logic                 load_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  loader_state_t state;
  logic          hold_full;
  logic [7:0]    hold_byte;
  logic [1:0]    idx;
  logic [31:0]   addr;
  logic [15:0]   count;
  logic [15:0]   words_left;
  logic [31:0]   wdata;
  logic [7:0]    sum;
  logic          valid;
  logic [3:0]    wstrb;
  logic          err_pend;
  logic          resp_ack;
  logic [TW-1:0] tmo_cnt;

  logic          consume;
  logic          in_frame;
  logic          overrun;
  logic          timeout;
  logic          err_now;
  logic [32:0]   win_end;
  logic          hdr_bad;

  assign bus.mem_valid = valid;
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_wstrb = wstrb;

  // The holding register is drained in every state that reads bytes; RESP
  // drains and drops, so stale bytes never leak into the next frame. CHECK
  // and WRITE leave it full so data waits there.
  always_comb begin
    consume = 1'b0;
    case (state)
      S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_DATA, S_SUM, S_RESP: consume = hold_full;
      default: consume = 1'b0;
    endcase
  end

  assign in_frame = (state != S_IDLE) && (state != S_RESP);
  assign overrun  = rx_received && hold_full && !consume;
  assign timeout  = in_frame && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_now  = in_frame && (rx_error || overrun || timeout);

  // 33-bit window end so an address near 2^32 cannot wrap below MAX_BYTES.
  assign win_end = {1'b0, addr} + {15'd0, count, 2'b00};
  assign hdr_bad = (addr[1:0] != 2'b00) || (win_end > 33'(MAX_BYTES));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      hold_full     <= 1'b0;
      hold_byte     <= 8'h00;
      idx           <= 2'd0;
      addr          <= 32'h0;
      count         <= 16'h0;
      words_left    <= 16'h0;
      wdata         <= 32'h0;
      sum           <= 8'h00;
      valid         <= 1'b0;
      wstrb         <= 4'b0000;
      err_pend      <= 1'b0;
      resp_ack      <= 1'b0;
      tmo_cnt       <= '0;
      tx_trigger    <= 1'b0;
      tx_byte       <= 8'h00;
      loader_active <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      tx_trigger <= 1'b0;
      load_done  <= 1'b0;

      // A byte with a simultaneous framing error is dropped.
      if (rx_received && !rx_error) begin
        hold_byte <= rx_byte;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end

      // Saturates at the limit so a timeout during WRITE stays asserted.
      if (!in_frame || consume) tmo_cnt <= '0;
      else if (!timeout)        tmo_cnt <= tmo_cnt + TW'(1);

      case (state)
        S_IDLE: begin
          if (consume && hold_byte == MAGIC) begin
            loader_active <= 1'b1;
            idx           <= 2'd0;
            sum           <= 8'h00;
            err_pend      <= 1'b0;
            state         <= S_HDR_ADDR;
          end
        end

        S_HDR_ADDR: begin
          if (err_now) begin
            resp_ack <= 1'b0;
            tx_byte  <= NAK_BYTE;
            state    <= S_RESP;
          end else if (consume) begin
            addr <= {hold_byte, addr[31:8]};
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              idx   <= 2'd0;
              state <= S_HDR_CNT;
            end
          end
        end

        S_HDR_CNT: begin
          if (err_now) begin
            resp_ack <= 1'b0;
            tx_byte  <= NAK_BYTE;
            state    <= S_RESP;
          end else if (consume) begin
            count <= {hold_byte, count[15:8]};
            idx   <= idx + 2'd1;
            if (idx == 2'd1) begin
              idx   <= 2'd0;
              state <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          if (err_now || hdr_bad) begin
            resp_ack <= 1'b0;
            tx_byte  <= NAK_BYTE;
            state    <= S_RESP;
          end else if (count == 16'd0) begin
            state <= S_SUM;
          end else begin
            words_left <= count;
            state      <= S_DATA;
          end
        end

        S_DATA: begin
          if (err_now) begin
            resp_ack <= 1'b0;
            tx_byte  <= NAK_BYTE;
            state    <= S_RESP;
          end else if (consume) begin
            // Shift right so the first byte ends up in wdata[7:0].
            wdata <= {hold_byte, wdata[31:8]};
            sum   <= sum + hold_byte;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              idx   <= 2'd0;
              valid <= 1'b1;
              wstrb <= 4'b1111;
              state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          // Errors are remembered and acted on once the handshake completes.
          if (err_now) err_pend <= 1'b1;
          if (bus.mem_ready) begin
            valid      <= 1'b0;
            wstrb      <= 4'b0000;
            addr       <= addr + 32'd4;
            words_left <= words_left - 16'd1;
            if (err_pend || err_now) begin
              resp_ack <= 1'b0;
              tx_byte  <= NAK_BYTE;
              state    <= S_RESP;
            end else if (words_left == 16'd1) begin
              state <= S_SUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_SUM: begin
          if (err_now) begin
            resp_ack <= 1'b0;
            tx_byte  <= NAK_BYTE;
            state    <= S_RESP;
          end else if (consume) begin
            resp_ack <= (hold_byte == sum);
            tx_byte  <= (hold_byte == sum) ? ACK_BYTE : NAK_BYTE;
            state    <= S_RESP;
          end
        end

        S_RESP: begin
          if (!tx_busy) begin
            tx_trigger    <= 1'b1;
            load_done     <= resp_ack;
            loader_active <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
